// File: rtl/floating_add_mult.sv
// rtl/floating_add_mult.sv - registered binary32 sum and product of one operand pair
// Both results are computed combinationally from a/b and captured on a start edge.
module floating_add_mult #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        sa, sb;
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;

  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;
  assign zero_a = (ea == 8'd0);
  assign zero_b = (eb == 8'd0);
  assign inf_a  = (ea == 8'hFF) && (fa == 23'd0);
  assign inf_b  = (eb == 8'hFF) && (fb == 23'd0);
  assign nan_a  = (ea == 8'hFF) && (fa != 23'd0);
  assign nan_b  = (eb == 8'hFF) && (fb != 23'd0);

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + 5'd1;
      end
    end
    return n;
  endfunction

  // Adder: 27-bit working significand = 24 bits + guard, round, sticky
  logic [31:0]       p_d;
  logic              swap, sl, ss, add_rnd;
  logic [7:0]        el, es, diff;
  logic [23:0]       ml, ms;
  logic [49:0]       ext;
  logic [26:0]       lx, sx, nm;
  logic [27:0]       sum;
  logic [4:0]        lz;
  logic signed [9:0] ne, re;
  logic [24:0]       rs;
  logic [22:0]       afrac;

  always_comb begin
    swap = {eb, fb} > {ea, fa};
    el   = swap ? eb : ea;
    es   = swap ? ea : eb;
    ml   = swap ? {1'b1, fb} : {1'b1, fa};
    ms   = swap ? {1'b1, fa} : {1'b1, fb};
    sl   = swap ? sb : sa;
    ss   = swap ? sa : sb;
    diff = el - es;
    ext  = {ms, 26'd0} >> diff;
    sx   = (diff >= 8'd26) ? 27'd1 : {ext[49:24], |ext[23:0]};
    lx   = {ml, 3'b000};
    sum  = (sl == ss) ? ({1'b0, lx} + {1'b0, sx}) : ({1'b0, lx} - {1'b0, sx});
    lz   = 5'd0;
    if (sum[27]) begin
      nm = {sum[27:2], sum[1] | sum[0]};
      ne = $signed({2'b00, el}) + 10'sd1;
    end else begin
      lz = lzc27(sum[26:0]);
      nm = sum[26:0] << lz;
      ne = $signed({2'b00, el}) - $signed({5'd0, lz});
    end
    add_rnd = nm[2] & (nm[1] | nm[0] | nm[3]);
    rs      = {1'b0, nm[26:3]} + {24'd0, add_rnd};
    if (rs[24]) begin
      re    = ne + 10'sd1;
      afrac = rs[23:1];
    end else begin
      re    = ne;
      afrac = rs[22:0];
    end

    if (nan_a || nan_b)                p_d = QNAN;
    else if (inf_a && inf_b && sa != sb) p_d = QNAN;
    else if (inf_a)                    p_d = a;
    else if (inf_b)                    p_d = b;
    else if (zero_a && zero_b)         p_d = {sa & sb, 31'd0};
    else if (zero_a)                   p_d = b;
    else if (zero_b)                   p_d = a;
    else if (sum == 28'd0)             p_d = 32'd0;
    else if (ne <= 10'sd0)             p_d = {sl, 31'd0};
    else if (re >= 10'sd255)           p_d = {sl, 8'hFF, 23'd0};
    else                               p_d = {sl, re[7:0], afrac};
  end

  // Multiplier: exponent kept signed so underflow shows up as <= 0
  logic [31:0]       result_d;
  logic              ms_sign, mul_g, mul_st, mul_rnd;
  logic [47:0]       prod;
  logic [23:0]       msig;
  logic signed [9:0] me, mre;
  logic [24:0]       mrs;
  logic [22:0]       mfrac;

  always_comb begin
    ms_sign = sa ^ sb;
    prod    = {24'd0, 1'b1, fa} * {24'd0, 1'b1, fb};
    me      = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    if (prod[47]) begin
      msig   = prod[47:24];
      mul_g  = prod[23];
      mul_st = |prod[22:0];
      me     = me + 10'sd1;
    end else begin
      msig   = prod[46:23];
      mul_g  = prod[22];
      mul_st = |prod[21:0];
    end
    mul_rnd = mul_g & (mul_st | msig[0]);
    mrs     = {1'b0, msig} + {24'd0, mul_rnd};
    if (mrs[24]) begin
      mre   = me + 10'sd1;
      mfrac = mrs[23:1];
    end else begin
      mre   = me;
      mfrac = mrs[22:0];
    end

    if (nan_a || nan_b)                                result_d = QNAN;
    else if ((inf_a && zero_b) || (inf_b && zero_a))   result_d = QNAN;
    else if (inf_a || inf_b)                           result_d = {ms_sign, 8'hFF, 23'd0};
    else if (zero_a || zero_b)                         result_d = {ms_sign, 31'd0};
    else if (me <= 10'sd0)                             result_d = {ms_sign, 31'd0};
    else if (mre >= 10'sd255)                          result_d = {ms_sign, 8'hFF, 23'd0};
    else                                               result_d = {ms_sign, mre[7:0], mfrac};
  end

  logic [31:0] p_q, result_q;
  logic        done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q      <= 32'd0;
      result_q <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      done_q <= start;
      if (start) begin
        p_q      <= p_d;
        result_q <= result_d;
      end
    end
  end

  assign p      = p_q;
  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_floating_add_mult.sv
// tb/tb_floating_add_mult.sv - scoreboard bench for floating_add_mult
module tb_floating_add_mult;

  typedef struct {
    logic [31:0] p;
    logic [31:0] r;
    logic        chk_p;
    logic        chk_r;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a, b, p, result;
  logic        done;
  int          tests = 0;
  int          fails = 0;
  exp_t        sb_q[$];

  always #5 clk = ~clk;

  floating_add_mult #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .p(p), .result(result), .done(done)
  );

  task automatic drive(input logic [31:0] ai, input logic [31:0] bi, input logic [31:0] ep,
                       input logic [31:0] er, input logic cp, input logic cr, input string nm);
    exp_t e;
    e.p = ep; e.r = er; e.chk_p = cp; e.chk_r = cr; e.name = nm;
    a = ai; b = bi; start = 1'b1;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1; start = 1'b0; a = 32'd0; b = 32'd0;
    @(posedge clk); #1;
    tests++;
    if (p !== 32'd0 || result !== 32'd0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_init: got p=%h result=%h done=%b, need 0/0/0", p, result, done);
    end
    rst = 1'b0;
    drive(32'h40000000, 32'h40000000, 32'h40800000, 32'h40800000, 1'b1, 1'b1, "pre_reset_op");
    @(posedge clk); #1;
    tests++;
    e = sb_q.pop_front();
    if (done !== 1'b1 || p !== e.p || result !== e.r) begin
      fails++;
      $display("FAIL %s: got done=%b p=%h result=%h, need done=1 p=%h result=%h",
               e.name, done, p, result, e.p, e.r);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (p !== 32'd0 || result !== 32'd0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_async: got p=%h result=%h done=%b, need 0/0/0", p, result, done);
    end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests++;
      if (p !== 32'd0 || result !== 32'd0 || done !== 1'b0) begin
        fails++;
        $display("FAIL reset_idle%0d: got p=%h result=%h done=%b, need 0/0/0", i, p, result, done);
      end
    end
  endtask

  task automatic test_single(input logic [31:0] ai, input logic [31:0] bi, input logic [31:0] ep,
                             input logic [31:0] er, input logic cp, input logic cr, input string nm);
    exp_t e;
    drive(ai, bi, ep, er, cp, cr, nm);
    @(posedge clk); #1;
    start = 1'b0;
    tests++;
    if (sb_q.size() == 0) begin
      fails++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb_q.pop_front();
      if (done !== 1'b1 || (e.chk_p && p !== e.p) || (e.chk_r && result !== e.r)) begin
        fails++;
        $display("FAIL %s: got done=%b p=%h result=%h, need done=1 p=%h result=%h",
                 e.name, done, p, result, e.p, e.r);
      end
    end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0 || (e.chk_p && p !== e.p) || (e.chk_r && result !== e.r)) begin
      fails++;
      $display("FAIL %s_hold: got done=%b p=%h result=%h, need done=0 p=%h result=%h",
               nm, done, p, result, e.p, e.r);
    end
  endtask

  task automatic test_scaling();
    test_single(32'h40000000, 32'h3F000000, 32'h40200000, 32'h3F800000, 1'b1, 1'b1, "scale_half");
  endtask

  task automatic test_cancel();
    test_single(32'h4034B4B5, 32'hBFB4B4B5, 32'h3FB4B4B5, 32'h0, 1'b1, 1'b0, "sub_exact");
    test_single(32'h3F800000, 32'hBF800000, 32'h00000000, 32'hBF800000, 1'b1, 1'b1, "cancel");
    test_single(32'h80000000, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, "neg_zeros");
  endtask

  task automatic test_rounding();
    test_single(32'h3FF0F0F1, 32'h3F400000, 32'h0, 32'h3FB4B4B5, 1'b0, 1'b1, "round_up");
    test_single(32'h3F800000, 32'h33800000, 32'h3F800000, 32'h33800000, 1'b1, 1'b1, "tie_even");
    test_single(32'h00000001, 32'h3F800000, 32'h3F800000, 32'h00000000, 1'b1, 1'b1, "subnormal_ftz");
  endtask

  task automatic test_specials();
    test_single(32'h7F000000, 32'h40000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b1, "mul_overflow");
    test_single(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 32'h7F800000, 1'b1, 1'b1, "add_overflow");
    test_single(32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'hFF800000, 1'b1, 1'b1, "inf_minus_inf");
    test_single(32'h7F800000, 32'h00000000, 32'h7F800000, 32'h7FC00000, 1'b1, 1'b1, "inf_times_zero");
    test_single(32'h7F800001, 32'h3F800000, 32'h7FC00000, 32'h7FC00000, 1'b1, 1'b1, "nan_in");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [31:0] av[3] = '{32'h3F800000, 32'h40400000, 32'h40000000};
    logic [31:0] bv[3] = '{32'h40000000, 32'h3F000000, 32'h40000000};
    logic [31:0] pv[3] = '{32'h40400000, 32'h40600000, 32'h40800000};
    logic [31:0] rv[3] = '{32'h40000000, 32'h3FC00000, 32'h40800000};
    for (int i = 0; i < 3; i++) begin
      drive(av[i], bv[i], pv[i], rv[i], 1'b1, 1'b1, $sformatf("b2b_%0d", i));
      @(posedge clk); #1;
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL b2b_%0d: scoreboard empty", i);
      end else begin
        e = sb_q.pop_front();
        if (done !== 1'b1 || p !== e.p || result !== e.r) begin
          fails++;
          $display("FAIL %s: got done=%b p=%h result=%h, need done=1 p=%h result=%h",
                   e.name, done, p, result, e.p, e.r);
        end
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0 || p !== 32'h40800000 || result !== 32'h40800000 || sb_q.size() != 0) begin
      fails++;
      $display("FAIL b2b_end: got done=%b p=%h result=%h pending=%0d, need done=0 p=40800000 result=40800000 pending=0",
               done, p, result, sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_scaling();
    test_cancel();
    test_rounding();
    test_specials();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
